// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//
// Multi-cycle 32-bit integer divider that uses restoring shift-and-subtract and
// produces one quotient bit per clock. A start pulse in IDLE latches the
// operands. busy_o is held high while the divide runs. done_o pulses for one
// cycle when the registered quotient, remainder and divide-by-zero flag are
// valid.
//
// Optional feature macro: DIVIDER_SIGNED_EN
//   defined     : signed_i selects signed (truncating) division; magnitude
//                 conversion and sign fix-up logic are built.
//   not defined : signed_i is ignored and all operands are unsigned.
//
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   start_i      in   1   request, accepted only in IDLE
//   signed_i     in   1   1 = signed operands (DIVIDER_SIGNED_EN only)
//   dividend_i   in  32   dividend, sampled at the accept edge
//   divisor_i    in  32   divisor, sampled at the accept edge
//   busy_o       out  1   high from the accept edge until the result edge
//   done_o       out  1   one-cycle pulse, results valid
//   quotient_o   out 32   quotient, held until the next result
//   remainder_o  out 32   remainder, held until the next result
//   div_zero_o   out  1   divisor was zero, held with the results
// -----------------------------------------------------------------------------
module iter_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        div_zero_o
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_r, state_nx;
    logic [5:0]          cnt_r;
    logic [DATA_W-1:0]   dq_r;       // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   rem_r;      // partial remainder
    logic [DATA_W-1:0]   dvs_r;      // divisor magnitude
    logic                dz_r;

    logic                accept;
    logic                div_zero_in;
    logic [DATA_W-1:0]   dvd_mag, dvs_mag;
    logic [DATA_W-1:0]   final_q, final_r;

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic                q_bit;

    assign accept      = (state_r == IDLE) && start_i;
    assign div_zero_in = (divisor_i == '0);

`ifdef DIVIDER_SIGNED_EN
    logic neg_q_r, neg_r_r;
    logic neg_q_in, neg_r_in;

    // Two's-complement negation when neg is set; used both for taking operand
    // magnitudes and for the final sign fix-up.
    function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                      input logic              neg);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        return neg ? -sv : sv;
    endfunction

    assign neg_q_in = signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
    assign neg_r_in = signed_i && dividend_i[DATA_W-1];
    assign dvd_mag  = cond_negate(dividend_i, signed_i && dividend_i[DATA_W-1]);
    assign dvs_mag  = cond_negate(divisor_i,  signed_i && divisor_i[DATA_W-1]);

    // -0x80000000 / -1 falls out naturally: the magnitude quotient 0x80000000 is
    // not negated because the operand signs match.
    assign final_q  = cond_negate(dq_r,  neg_q_r);
    assign final_r  = cond_negate(rem_r, neg_r_r);
`else
    logic signed_unused;
    assign signed_unused = signed_i;
    assign dvd_mag       = dividend_i;
    assign dvs_mag       = divisor_i;
    assign final_q       = dq_r;
    assign final_r       = rem_r;
`endif

    // One restoring step. The compare is 33 bits wide because the shifted
    // remainder can exceed 32 bits when the divisor is above 2^31.
    assign shifted = {rem_r, dq_r[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_r};
    assign q_bit   = ~diff[DATA_W];

    // ---- FSM: next state and busy --------------------------------------------
    always_comb begin
        state_nx = state_r;
        busy_o   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nx = div_zero_in ? FIN : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (cnt_r == 6'd31) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                busy_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---- Control and result registers (async reset) --------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            done_o      <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            state_r <= state_nx;
            done_o  <= (state_r == FIN);
            if (accept) begin
                cnt_r      <= '0;
                div_zero_o <= 1'b0;
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + 6'd1;
            end
            if (state_r == FIN) begin
                quotient_o  <= final_q;
                remainder_o <= final_r;
                div_zero_o  <= dz_r;
            end
        end
    end

    // ---- Datapath registers (no reset; always loaded at accept) --------------
    always_ff @(posedge clk_i) begin
        if (accept) begin
            dvs_r <= dvs_mag;
            dz_r  <= div_zero_in;
            if (div_zero_in) begin
                // Divide by zero skips the iterations; load the fixed result.
                dq_r  <= '1;
                rem_r <= dividend_i;
            end else begin
                dq_r  <= dvd_mag;
                rem_r <= '0;
            end
`ifdef DIVIDER_SIGNED_EN
            neg_q_r <= neg_q_in && !div_zero_in;
            neg_r_r <= neg_r_in && !div_zero_in;
`endif
        end else if (state_r == RUN) begin
            dq_r  <= {dq_r[DATA_W-2:0], q_bit};
            rem_r <= q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// -----------------------------------------------------------------------------
// tb_iter_divider
//
// Directed self-checking bench for iter_divider. Expected values are worked
// out by hand for each vector. Signed vectors are active only when
// DIVIDER_SIGNED_EN is defined; otherwise the same slots check that unsigned
// behaviour holds.
// -----------------------------------------------------------------------------
module tb_iter_divider;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_zero_o;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc;
    int pulses;

    iter_divider dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div_zero_o  (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns 1 time unit after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk_i);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Count edges until done_o is seen, bounded at 40.
    task automatic wait_done(output int c);
        bit seen;
        seen = 1'b0;
        c    = 0;
        while (!seen && c < 40) begin
            @(posedge clk_i);
            #1;
            c++;
            seen = done_o;
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_q", quotient_o, 0);
        check("rst_r", remainder_o, 0);
        check("rst_dz", div_zero_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // 100 / 7
        start_op(32'd100, 32'd7, 1'b0);
        check("u100_busy", busy_o, 1);
        wait_done(cyc);
        check("u100_lat", cyc, 33);
        check("u100_busy_end", busy_o, 0);
        check("u100_q", quotient_o, 32'd14);
        check("u100_r", remainder_o, 32'd2);
        check("u100_dz", div_zero_o, 0);
        @(posedge clk_i);
        #1;
        check("u100_done_pulse", done_o, 0);
        check("u100_q_hold", quotient_o, 32'd14);

        // 12345 / 0
        start_op(32'd12345, 32'd0, 1'b0);
        wait_done(cyc);
        check("dz_lat", cyc, 1);
        check("dz_q", quotient_o, 32'hFFFFFFFF);
        check("dz_r", remainder_o, 32'd12345);
        check("dz_flag", div_zero_o, 1);

        // 0x80000000 / 0xFFFFFFFF
`ifdef DIVIDER_SIGNED_EN
        start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
        check("accept_clears_dz", div_zero_o, 0);
        check("accept_keeps_q", quotient_o, 32'hFFFFFFFF);
        wait_done(cyc);
        check("ovf_lat", cyc, 33);
        check("ovf_q", quotient_o, 32'h80000000);
        check("ovf_r", remainder_o, 32'h0);
        check("ovf_dz", div_zero_o, 0);

        start_op(32'hFFFFFFF9, 32'd2, 1'b1);   // -7 / 2
        wait_done(cyc);
        check("s_m7_2_q", quotient_o, 32'hFFFFFFFD);
        check("s_m7_2_r", remainder_o, 32'hFFFFFFFF);

        start_op(32'd7, 32'hFFFFFFFE, 1'b1);   // 7 / -2
        wait_done(cyc);
        check("s_7_m2_q", quotient_o, 32'hFFFFFFFD);
        check("s_7_m2_r", remainder_o, 32'd1);
`else
        start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
        check("accept_clears_dz", div_zero_o, 0);
        check("accept_keeps_q", quotient_o, 32'hFFFFFFFF);
        wait_done(cyc);
        check("ovf_lat", cyc, 33);
        check("ovf_q", quotient_o, 32'h0);
        check("ovf_r", remainder_o, 32'h80000000);
        check("ovf_dz", div_zero_o, 0);

        start_op(32'hFFFFFFF9, 32'd2, 1'b1);   // signed_i ignored
        wait_done(cyc);
        check("u_fff9_2_q", quotient_o, 32'h7FFFFFFC);
        check("u_fff9_2_r", remainder_o, 32'd1);
`endif

        // 0xFFFFFFFF / 3 with a stray start at E10
        start_op(32'hFFFFFFFF, 32'd3, 1'b0);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        dividend_i = 32'd5;
        divisor_i  = 32'd1;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("ign_busy", busy_o, 1);
        wait_done(cyc);
        check("ign_lat", cyc, 23);
        check("ign_q", quotient_o, 32'h55555555);
        check("ign_r", remainder_o, 32'h0);

        // back-to-back start in the done cycle: 9 / 4
        dividend_i = 32'd9;
        divisor_i  = 32'd4;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("b2b_busy", busy_o, 1);
        check("b2b_done", done_o, 0);
        wait_done(cyc);
        check("b2b_lat", cyc, 33);
        check("b2b_q", quotient_o, 32'd2);
        check("b2b_r", remainder_o, 32'd1);

        // reset in the middle of a run
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("mrst_busy", busy_o, 0);
        check("mrst_done", done_o, 0);
        check("mrst_q", quotient_o, 0);
        check("mrst_r", remainder_o, 0);
        check("mrst_dz", div_zero_o, 0);
        @(negedge clk_i);
        rst_i  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) pulses++;
        end
        check("mrst_no_done", pulses, 0);

        start_op(32'd9, 32'd3, 1'b0);
        wait_done(cyc);
        check("post_rst_lat", cyc, 33);
        check("post_rst_q", quotient_o, 32'd3);
        check("post_rst_r", remainder_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
